// File: rtl/top_ting.sv
// top_ting: double-and-add EC scalar multiply k*P over GF(p), p<16; ports: i_clk/i_rst, i_start, a/prime/k/Px/Py in, kPx/kPy accumulator, final_output_1/2 + final_done result, raw1 debug
module top_ting #(
  parameter int SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [3:0]      a,
  input  logic [3:0]      prime,
  input  logic [3:0]      k,
  input  logic [3:0]      Px,
  input  logic [3:0]      Py,
  output logic [SIZE-1:0] kPx,
  output logic [SIZE-1:0] kPy,
  output logic [SIZE-1:0] final_output_1,
  output logic [SIZE-1:0] final_output_2,
  output logic            final_done,
  output logic [31:0]     raw1
);
  typedef enum logic [3:0] {IDLE, LOAD, DBL, ADD, INV, UPD, NXT, DONE} state_t;
  state_t st_q;
  logic [3:0] a_q, p_q, k_q, px_q, py_q, x_q, y_q, bit_q, v_q, num_q, den_q, lam_q, fx_q, fy_q;
  logic inf_q, add_q, done_q;
  logic [3:0] xn, yn;
  function automatic logic [9:0] w(input logic [3:0] v);
    w = {6'b0, v};
  endfunction
  function automatic logic [3:0] md(input logic [9:0] v);
    md = 4'(v % w(p_q));
  endfunction
  // x2 is P.x in an add step; when an add falls back to doubling, x equals P.x anyway
  always_comb begin
    xn = md(w(md(w(lam_q) * w(lam_q))) + (w(p_q) << 1) - w(x_q) - w(add_q ? px_q : x_q));
    yn = md(w(lam_q) * w(md(w(x_q) + w(p_q) - w(xn))) + w(p_q) - w(y_q));
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      st_q <= IDLE;
      {a_q, p_q, k_q, px_q, py_q, x_q, y_q, bit_q, v_q} <= '0;
      {num_q, den_q, lam_q, fx_q, fy_q} <= '0;
      {inf_q, add_q, done_q} <= '0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        IDLE: if (i_start) st_q <= LOAD;
        LOAD: begin
          {a_q, p_q, k_q, px_q, py_q} <= {a, prime, k, Px, Py};
          {x_q, y_q} <= '0;
          inf_q <= 1'b1;
          add_q <= 1'b0;
          bit_q <= 4'd3;
          st_q <= DBL;
        end
        DBL: begin
          if (inf_q || y_q == 4'd0) begin
            inf_q <= 1'b1;
            st_q <= NXT;
          end else begin
            num_q <= md(w(md(w(x_q) * w(x_q))) * 10'd3 + w(a_q));
            den_q <= md(w(y_q) << 1);
            v_q <= 4'd1;
            st_q <= INV;
          end
        end
        ADD: begin
          if (inf_q) begin
            {x_q, y_q} <= {px_q, py_q};
            inf_q <= 1'b0;
            st_q <= NXT;
          end else if (x_q == px_q) begin
            inf_q <= (y_q != py_q);
            st_q <= (y_q == py_q) ? DBL : NXT;
          end else begin
            num_q <= md(w(py_q) + w(p_q) - w(y_q));
            den_q <= md(w(px_q) + w(p_q) - w(x_q));
            v_q <= 4'd1;
            st_q <= INV;
          end
        end
        // linear search for den^-1; v==15 bounds the loop for illegal moduli
        INV: begin
          if (md(w(den_q) * w(v_q)) == 4'd1 || v_q == 4'd15) begin
            lam_q <= md(w(num_q) * w(v_q));
            st_q <= UPD;
          end else v_q <= v_q + 4'd1;
        end
        UPD: begin
          {x_q, y_q} <= {xn, yn};
          st_q <= NXT;
        end
        NXT: begin
          if (!add_q && k_q[bit_q[1:0]]) begin
            add_q <= 1'b1;
            st_q <= ADD;
          end else if (bit_q == 4'd0) st_q <= DONE;
          else begin
            bit_q <= bit_q - 4'd1;
            add_q <= 1'b0;
            st_q <= DBL;
          end
        end
        DONE: begin
          fx_q <= inf_q ? 4'd0 : x_q;
          fy_q <= inf_q ? 4'd0 : y_q;
          done_q <= 1'b1;
          st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign kPx = SIZE'(inf_q ? 4'd0 : x_q);
  assign kPy = SIZE'(inf_q ? 4'd0 : y_q);
  assign final_output_1 = SIZE'(fx_q);
  assign final_output_2 = SIZE'(fy_q);
  assign final_done = done_q;
  assign raw1 = {20'b0, st_q, bit_q, v_q};
endmodule

// File: tb/tb_top_ting.sv
// tb_top_ting: directed checks of top_ting on y^2 = x^3 + x + 6 mod 11, P = (2,7)
module tb_top_ting;
  logic i_clk = 0, i_rst = 0, i_start = 0;
  logic [3:0] a = 4'd1, prime = 4'd11, k = 4'd0, Px = 4'd2, Py = 4'd7;
  logic [31:0] kPx, kPy, final_output_1, final_output_2, raw1;
  logic final_done;
  int tests = 0, fails = 0, dones = 0;
  top_ting dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .a(a), .prime(prime), .k(k),
    .Px(Px), .Py(Py), .kPx(kPx), .kPy(kPy), .final_output_1(final_output_1),
    .final_output_2(final_output_2), .final_done(final_done), .raw1(raw1)
  );
  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (final_done) dones++;
  task automatic check_zero(input string nm);
    tests++;
    if ({kPx, kPy, final_output_1, final_output_2, raw1, final_done} !== '0) begin
      fails++;
      $display("FAIL %s: kPx=%0d kPy=%0d f1=%0d f2=%0d raw1=%h done=%b, all should be 0",
               nm, kPx, kPy, final_output_1, final_output_2, raw1, final_done);
    end
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (!final_done && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    tests++;
    if (!final_done) begin
      fails++;
      $display("FAIL %s_timeout: no final_done within 2000 cycles", nm);
    end
  endtask
  task automatic check_res(input logic [31:0] ex, input logic [31:0] ey, input string nm);
    tests++;
    if (final_output_1 !== ex || final_output_2 !== ey) begin
      fails++;
      $display("FAIL %s_result: got (%0d,%0d) expected (%0d,%0d)", nm, final_output_1, final_output_2, ex, ey);
    end
    tests++;
    if (kPx !== ex || kPy !== ey) begin
      fails++;
      $display("FAIL %s_acc: kP=(%0d,%0d) expected (%0d,%0d)", nm, kPx, kPy, ex, ey);
    end
  endtask
  task automatic check_dones(input int d0, input int exp_n, input string nm);
    tests++;
    if (dones - d0 != exp_n) begin
      fails++;
      $display("FAIL %s_dones: got %0d pulses expected %0d", nm, dones - d0, exp_n);
    end
  endtask
  task automatic run_k(input logic [3:0] kv, input logic [31:0] ex, input logic [31:0] ey, input string nm);
    int d0;
    @(negedge i_clk);
    d0 = dones;
    k = kv;
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    wait_done(nm);
    check_res(ex, ey, nm);
    repeat (300) @(negedge i_clk);
    check_dones(d0, 1, nm);
    tests++;
    if (final_output_1 !== ex || final_output_2 !== ey) begin
      fails++;
      $display("FAIL %s_hold: got (%0d,%0d) expected (%0d,%0d)", nm, final_output_1, final_output_2, ex, ey);
    end
  endtask
  task automatic test_reset;
    i_rst = 0;
    @(negedge i_clk);
    check_zero("reset_active");
    i_rst = 1;
    repeat (20) @(negedge i_clk);
    check_zero("reset_idle");
    check_dones(0, 0, "reset_idle");
  endtask
  task automatic test_basic;
    run_k(4'd1, 32'd2, 32'd7, "k1");
    run_k(4'd2, 32'd5, 32'd2, "k2");
    run_k(4'd7, 32'd7, 32'd2, "k7");
    run_k(4'd12, 32'd2, 32'd4, "k12");
    run_k(4'd13, 32'd0, 32'd0, "k13");
    run_k(4'd0, 32'd0, 32'd0, "k0");
  endtask
  task automatic test_busy_restart;
    int d0;
    run_k(4'd2, 32'd5, 32'd2, "pre_busy");
    @(negedge i_clk);
    d0 = dones;
    k = 4'd7;
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    repeat (5) @(negedge i_clk);
    tests++;
    if (final_output_1 !== 32'd5 || final_output_2 !== 32'd2) begin
      fails++;
      $display("FAIL busy_keep: got (%0d,%0d) expected (5,2)", final_output_1, final_output_2);
    end
    k = 4'd1;
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    wait_done("busy");
    check_res(32'd7, 32'd2, "busy");
    repeat (300) @(negedge i_clk);
    check_dones(d0, 1, "busy");
  endtask
  task automatic test_reset_mid;
    int d0;
    @(negedge i_clk);
    d0 = dones;
    k = 4'd7;
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    repeat (30) @(negedge i_clk);
    #2 i_rst = 0;
    #1 check_zero("mid_reset_async");
    @(negedge i_clk);
    i_rst = 1;
    repeat (300) @(negedge i_clk);
    check_zero("mid_reset_after");
    check_dones(d0, 0, "mid_reset");
    run_k(4'd3, 32'd8, 32'd3, "k3");
  endtask
  task automatic test_back_to_back;
    int d0;
    @(negedge i_clk);
    d0 = dones;
    k = 4'd2;
    i_start = 1;
    wait_done("b2b_first");
    check_res(32'd5, 32'd2, "b2b_first");
    k = 4'd3;
    @(negedge i_clk);
    wait_done("b2b_second");
    i_start = 0;
    check_res(32'd8, 32'd3, "b2b_second");
    repeat (300) @(negedge i_clk);
    check_dones(d0, 2, "b2b");
  endtask
  initial begin
    test_reset;
    test_basic;
    test_busy_restart;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
